// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : cpu_phase_sequencer
//  Description: FETCH/EXEC1/EXEC2 phase sequencer with run/step/stop control
//               and cycle / retired-instruction counters.
//  Revision   : 1.0 - initial release
// ============================================================================
module cpu_phase_sequencer #(
  parameter int         WORD_W = 16,
  parameter int         CNT_W  = 16,
  parameter logic [3:0] STP_OP = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [WORD_W-1:0] instr,
  input  logic              extra,
  output logic              fetch,
  output logic              exec1,
  output logic              exec2,
  output logic [3:0]        ir,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC1   = 3'd2,
    ST_EXEC2   = 3'd3,
    ST_STOPPED = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  state_t w_after_retire;
  logic   w_retire;
  logic   w_is_stp;
  logic   w_instr_unused;

  // Only the opcode nibble matters here; operand bits belong to the datapath.
  assign w_instr_unused = ^instr[WORD_W-5:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_retire       = 1'b0;
    w_is_stp       = (ir == STP_OP);
    w_after_retire = run ? ST_FETCH : ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (run || step) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = ST_EXEC1;
      end
      ST_EXEC1: begin
        if (w_is_stp) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_STOPPED;
        end else if (extra) begin
          w_state_nxt = ST_EXEC2;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = w_after_retire;
        end
      end
      ST_EXEC2: begin
        w_retire    = 1'b1;
        w_state_nxt = w_after_retire;
      end
      ST_STOPPED: begin
        w_state_nxt = ST_STOPPED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RETIRE follows EXTRA combinationally during EXEC1, so it is not registered.
  assign retire = w_retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      fetch     <= 1'b0;
      exec1     <= 1'b0;
      exec2     <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      ir        <= 4'd0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      fetch   <= (w_state_nxt == ST_FETCH);
      exec1   <= (w_state_nxt == ST_EXEC1);
      exec2   <= (w_state_nxt == ST_EXEC2);
      busy    <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC1) ||
                 (w_state_nxt == ST_EXEC2);
      halted  <= (w_state_nxt == ST_STOPPED);
      if (r_state == ST_FETCH) ir <= instr[WORD_W-1 -: 4];
      if (busy) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (w_retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
